// File: rtl/bcd_conv_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble).
// One binary word is accepted per in_valid/in_ready handshake, shifted one bit per clock,
// and the packed BCD result is offered under an out_valid/out_ready handshake.
module bcd_conv_seq #(
  parameter int unsigned IN_W   = 9,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic [IN_W-1:0]       in_bin_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [4*DIGITS-1:0]   out_bcd_o,
  input  logic                  out_ready_i
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(IN_W + 1);
  // Decimal digits of 2**IN_W-1 equal floor(IN_W*log10(2))+1 (2**n is never a power of ten).
  localparam int unsigned MinDigits = (IN_W * 30103) / 100000 + 1;

  if (IN_W < 1) begin : g_bad_width
    $error("bcd_conv_seq: IN_W must be at least 1");
  end
  if (DIGITS < MinDigits) begin : g_bad_digits
    $error("bcd_conv_seq: DIGITS too small to hold 2**IN_W-1");
  end

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   out_q, out_d;

  logic [BcdW-1:0]   bcd_adj;
  logic [BcdW-1:0]   bcd_shift;
  logic [IN_W-1:0]   bin_shift;

  // Add 3 to every nibble >= 5 in parallel; a nibble <= 9 never carries into its neighbour.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // {bcd, bin} shifted left by one: the binary MSB moves into the BCD LSB.
  assign bcd_shift = {bcd_adj[BcdW-2:0], bin_q[IN_W-1]};
  assign bin_shift = bin_q << 1;

  // Next-state logic: accept in IDLE, IN_W shift cycles, hold result in DONE.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          bin_d   = in_bin_i;
          bcd_d   = '0;
          cnt_d   = CntW'(IN_W);
          state_d = StShift;
        end
      end
      StShift: begin
        bin_d = bin_shift;
        bcd_d = bcd_shift;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          out_d   = bcd_shift;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign out_bcd_o   = out_q;

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Scoreboard bench for bcd_conv_seq: a default 9-bit/3-digit instance and a 16-bit/5-digit one.
module tb_bcd_conv_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0;
  logic [8:0]  a_in_bin   = '0;
  logic        a_in_ready;
  logic        a_out_valid;
  logic [11:0] a_out_bcd;
  logic        a_out_ready = 1'b1;

  logic        b_in_valid = 1'b0;
  logic [15:0] b_in_bin   = '0;
  logic        b_in_ready;
  logic        b_out_valid;
  logic [19:0] b_out_bcd;
  logic        b_out_ready = 1'b1;

  bcd_conv_seq #(.IN_W(9), .DIGITS(3)) u_dut_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (a_in_valid),
    .in_bin_i    (a_in_bin),
    .in_ready_o  (a_in_ready),
    .out_valid_o (a_out_valid),
    .out_bcd_o   (a_out_bcd),
    .out_ready_i (a_out_ready)
  );

  bcd_conv_seq #(.IN_W(16), .DIGITS(5)) u_dut_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (b_in_valid),
    .in_bin_i    (b_in_bin),
    .in_ready_o  (b_in_ready),
    .out_valid_o (b_out_valid),
    .out_bcd_o   (b_out_bcd),
    .out_ready_i (b_out_ready)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_a[$];
  logic [19:0] exp_b[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference by repeated /10 and %10.
  function automatic logic [19:0] bcd_model(input int unsigned v, input int nd);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop and compare whenever a result handshake is about to happen.
  always @(negedge clk) begin
    logic [11:0] ea;
    logic [19:0] eb;
    if (!rst && a_out_valid && a_out_ready) begin
      if (exp_a.size() == 0) check("a_spurious", a_out_valid, 1'b0);
      else begin
        ea = exp_a.pop_front();
        check("a_bcd", a_out_bcd, ea);
      end
    end
    if (!rst && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) check("b_spurious", b_out_valid, 1'b0);
      else begin
        eb = exp_b.pop_front();
        check("b_bcd", b_out_bcd, eb);
      end
    end
  end

  // One conversion on instance A with out_ready held high; checks latency and in_ready.
  task automatic do_a(input logic [8:0] v, input logic [11:0] e);
    int t, lat, rh;
    t = 0;
    while (!a_in_ready && t < 50) begin step(); t++; end
    check("a_in_ready_idle", a_in_ready, 1'b1);
    a_in_bin = v; a_in_valid = 1'b1;
    exp_a.push_back(e);
    step();
    a_in_valid = 1'b0; a_in_bin = 9'($urandom);
    lat = 0; rh = 0;
    while (!a_out_valid && lat < 40) begin
      if (a_in_ready) rh++;
      step();
      lat++;
    end
    if (a_in_ready) rh++;
    check("a_latency", lat, 9);
    check("a_ready_busy", rh, 0);
    step();
    check("a_idle_after", {a_in_ready, a_out_valid}, 2'b10);
  endtask

  task automatic do_b(input logic [15:0] v, input logic [19:0] e);
    int t, lat;
    t = 0;
    while (!b_in_ready && t < 50) begin step(); t++; end
    check("b_in_ready_idle", b_in_ready, 1'b1);
    b_in_bin = v; b_in_valid = 1'b1;
    exp_b.push_back(e);
    step();
    b_in_valid = 1'b0; b_in_bin = 16'($urandom);
    lat = 0;
    while (!b_out_valid && lat < 60) begin step(); lat++; end
    check("b_latency", lat, 16);
    step();
    check("b_idle_after", {b_in_ready, b_out_valid}, 2'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_v, bad;
    logic [11:0] held;
    // Reset state
    rst = 1'b1;
    a_in_valid = 1'b1; a_in_bin = 9'd123;  // must be ignored under reset
    repeat (3) step();
    check("rst_a", {a_in_ready, a_out_valid, a_out_bcd}, {1'b1, 1'b0, 12'h000});
    check("rst_b", {b_in_ready, b_out_valid, b_out_bcd}, {1'b1, 1'b0, 20'h00000});
    a_in_valid = 1'b0;
    rst = 1'b0;
    step();

    // Zero, then the named values
    do_a(9'd0,   12'h000);
    do_a(9'd511, 12'h511);
    do_a(9'd255, 12'h255);
    do_a(9'd100, 12'h100);

    // Exhaustive sweep against the division model
    for (int v = 0; v < 512; v++) do_a(9'(v), bcd_model(v, 3)[11:0]);

    // Backpressure: result must hold while out_ready is low
    a_out_ready = 1'b0;
    a_in_bin = 9'd437; a_in_valid = 1'b1;
    exp_a.push_back(12'h437);
    step();
    a_in_valid = 1'b0; a_in_bin = 9'd0;
    bad = 0;
    held = 12'h437;
    for (int i = 0; i < 20; i++) begin
      if (a_in_ready) bad++;
      if (a_out_valid && a_out_bcd !== held) bad++;
      step();
    end
    check("bp_valid", a_out_valid, 1'b1);
    check("bp_bcd", a_out_bcd, 12'h437);
    check("bp_stable", bad, 0);
    a_out_ready = 1'b1;
    step();
    check("bp_release", {a_in_ready, a_out_valid}, 2'b10);

    // Reset during shift cycle 4 discards the conversion
    a_in_bin = 9'd300; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_state", {a_in_ready, a_out_valid}, 2'b10);
    cnt_v = 0;
    for (int i = 0; i < 15; i++) begin
      if (a_out_valid) cnt_v++;
      step();
    end
    check("mid_rst_no_valid", cnt_v, 0);
    do_a(9'd42, 12'h042);

    // Wide instance
    do_b(16'd65535, 20'h65535);
    do_b(16'd10000, 20'h10000);
    do_b(16'd0,     20'h00000);
    do_b(16'd9999,  bcd_model(9999, 5));

    step();
    check("a_drain", exp_a.size(), 0);
    check("b_drain", exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
